stdp_stim_sequencer: RTL and testbench
======================================

Name: stdp_stim_sequencer

Overview:
- On-chip stimulus generator for the two-neuron Hodgkin-Huxley STDP core. It drives the core's current inputs: `i_pre` goes to the ui_in current of neuron 1, `i_post` to the uio_in current of neuron 2.
- It also consumes the two neurons' spike flags, so it is the transmit end of the current/spike interface that the bench currently drives by hand.
- It runs the training schedule (rest, then N pre→gap→post→gap→rest pairs, then a pre-only test window), counts spikes and reports pass/fail.

Parameters:
- CUR_W, 8, current word width.
- CNT_W, 16, spike counter width.
- INIT_CYC, 25, initial rest length in clk cycles.
- PRE_CYC, 5, pre-synaptic pulse length.
- GAP_CYC, 3, gap after each pulse.
- POST_CYC, 5, post-synaptic pulse length.
- REST_CYC, 10, rest after each pair.
- TEST_CYC, 100, pre-only test window length.
- All *_CYC parameters must be ≥1; this is checked by an elaboration assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a run
- abort  in  1  return to idle immediately
- amp_pre  in  CUR_W  pre pulse amplitude, latched on start
- amp_post  in  CUR_W  post pulse amplitude, latched on start
- n_pairs  in  8  training pair count, latched on start
- spike_pre  in  1  neuron 1 spike flag, same clock domain
- spike_post  in  1  neuron 2 spike flag, same clock domain
- i_pre  out  CUR_W  current to neuron 1
- i_post  out  CUR_W  current to neuron 2
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run completion
- phase  out  3  current state encoding
- pair_idx  out  8  index of the pair in progress, 0-based
- cnt_pre  out  CNT_W  neuron 1 spike count
- cnt_post  out  CNT_W  neuron 2 spike count
- pass  out  1  pass/fail result

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low (rst_n). All outputs reset to 0 and the state resets to IDLE.
- States and phase encoding: IDLE=0, INIT=1, PRE=2, GAP1=3, POST=4, GAP2=5, REST=6, TEST=7.
- Timing: each timed state lasts exactly its *_CYC cycles. It uses one down-counter, loaded with CYC-1 on entry; the transition happens when the counter reaches 0.
- Start: in IDLE, start sampled high at edge k causes:
  - amp_pre, amp_post and n_pairs latched;
  - cnt_pre, cnt_post and pass cleared;
  - pair_idx set to 0;
  - state INIT and busy=1 from edge k.
- start while busy is ignored.
- Transitions:
  - INIT→PRE, or INIT→TEST if the latched n_pairs=0.
  - PRE→GAP1→POST→GAP2→REST.
  - REST→PRE with pair_idx+1 if pair_idx+1 < n_pairs, otherwise REST→TEST.
  - TEST→IDLE.
- Completion: on leaving TEST, busy=0 and done=1 for one cycle, both at the same edge. pass = (cnt_pre≠0) && (cnt_post≠0), computed including any spike in the final TEST cycle.
- Outputs are registered and decoded from the next state, so they align with phase:
  - i_pre = latched amp_pre in PRE and TEST, 0 otherwise.
  - i_post = latched amp_post in POST, 0 otherwise.
- Spike counting:
  - Counters count rising edges of the spike inputs, registered edge detect; a flag held high counts once.
  - cnt_pre counts over the whole run (INIT..TEST).
  - cnt_post counts only while in TEST (synaptic response).
  - Both counters saturate at 2^CNT_W−1.
  - Edge-detect history registers update in every state, including IDLE.
- Hold behaviour: counters, pass and pair_idx hold after completion until the next start.
- Abort: abort has priority over all transitions. Next edge: state IDLE, currents 0, busy 0, no done pulse, pass 0; counters hold. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins, so the run is not started.
- Reset mid-run: outputs return to 0 asynchronously.

Optional Feature:
- Macro: STDP_SEQ_ANTI_EN.
- When defined, an extra input anti (1 bit, latched on start) is added. If anti=1:
  - PRE and POST amplitudes swap targets: the post pulse drives neuron 2 first (in the PRE slot) and the pre pulse drives neuron 1 second (in the POST slot). This is anti-causal depression training.
  - TEST is unchanged.
- When undefined, the port is absent and order is always pre→post.

Decomposition:
- Package stdp_seq_pkg holds:
  - state enum plus the phase constants 0..7;
  - default cycle-length constants;
  - CNT_W default.
- Sub-module spike_edge_counter: rising-edge detect, enable input, synchronous clear, saturating CNT_W count. Two instances.

Test Plan:
- Reset, amp_pre=0x80, amp_post=0x80, n_pairs=2, start pulse, defaults → busy high exactly 25+2·26+100=177 cycles; done pulses once immediately after; phase sequence 1,2,3,4,5,6,2,…,7,0; i_pre=0x80 only in PRE/TEST; i_post=0x80 only in POST.
- Same run with spike_pre toggled once per PRE and held high 3 cycles in TEST, spike_post pulsed twice in TEST and once in POST → cnt_pre=3, cnt_post=2, pass=1.
- n_pairs=0 → INIT (25 cycles) goes directly to TEST (100); busy 125 cycles; i_post never nonzero.
- abort asserted in pair 1 GAP1 → next edge phase=0, currents 0, busy 0, no done; a following start runs normally with counters cleared.
- start re-asserted during busy and start+abort together in IDLE → no state change in either case; rst_n dropped mid-PRE → i_pre=0 without waiting for clk.
- With STDP_SEQ_ANTI_EN, anti=1, n_pairs=1 → i_post=amp_post in the PRE slot, i_pre=amp_pre in the POST slot; TEST drives i_pre only.

Source files
------------

// File: rtl/stdp_seq_pkg.sv
// rtl/stdp_seq_pkg.sv - shared types and defaults for the STDP stimulus sequencer
// Contents:
//   PH_*          phase codes driven on the sequencer's phase output
//   state_e       sequencer state enum, encoded with the phase codes
//   DEF_*_CYC     default lengths of each timed state, in clk cycles
//   DEF_CNT_W     default spike counter width
package stdp_seq_pkg;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_INIT = 3'd1;
  localparam logic [2:0] PH_PRE  = 3'd2;
  localparam logic [2:0] PH_GAP1 = 3'd3;
  localparam logic [2:0] PH_POST = 3'd4;
  localparam logic [2:0] PH_GAP2 = 3'd5;
  localparam logic [2:0] PH_REST = 3'd6;
  localparam logic [2:0] PH_TEST = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = PH_IDLE,
    ST_INIT = PH_INIT,
    ST_PRE  = PH_PRE,
    ST_GAP1 = PH_GAP1,
    ST_POST = PH_POST,
    ST_GAP2 = PH_GAP2,
    ST_REST = PH_REST,
    ST_TEST = PH_TEST
  } state_e;

  localparam int DEF_INIT_CYC = 25;
  localparam int DEF_PRE_CYC  = 5;
  localparam int DEF_GAP_CYC  = 3;
  localparam int DEF_POST_CYC = 5;
  localparam int DEF_REST_CYC = 10;
  localparam int DEF_TEST_CYC = 100;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/spike_edge_counter.sv
// rtl/spike_edge_counter.sv - rising-edge spike counter with enable, clear and saturation
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           count rising edges only while high
//   clr          synchronous clear, wins over counting
//   spike        spike flag (same clock domain)
//   count        registered count
//   count_nxt    value count takes at the next edge
module spike_edge_counter
  import stdp_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             spike,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;

  always_comb begin
    // history follows the input every cycle, enabled or not
    prev_d  = spike;
    rise    = spike & ~prev_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && rise && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/stdp_stim_sequencer.sv
// rtl/stdp_stim_sequencer.sv - STDP training stimulus sequencer for the two-neuron HH core
// Runs rest, n_pairs x (pre, gap, post, gap, rest), then a pre-only test window,
// counting neuron spikes and reporting pass when both neurons fired.
// Optional feature macro: STDP_SEQ_ANTI_EN adds the 'anti' input (post-then-pre order).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          run request (IDLE only) / return to IDLE (wins over everything)
//   amp_pre, amp_post     pulse amplitudes, latched on start
//   n_pairs               training pair count, latched on start
//   anti                  (STDP_SEQ_ANTI_EN only) swap pulse order, latched on start
//   spike_pre/post        neuron 1/2 spike flags
//   i_pre, i_post         currents to neuron 1/2
//   busy, done            run in progress / one-cycle completion pulse
//   phase, pair_idx       current state code / 0-based pair in progress
//   cnt_pre, cnt_post     spike counts, pass = both nonzero at completion
module stdp_stim_sequencer
  import stdp_seq_pkg::*;
#(
  parameter int CUR_W    = 8,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INIT_CYC = DEF_INIT_CYC,
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int POST_CYC = DEF_POST_CYC,
  parameter int REST_CYC = DEF_REST_CYC,
  parameter int TEST_CYC = DEF_TEST_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CUR_W-1:0] amp_pre,
  input  logic [CUR_W-1:0] amp_post,
  input  logic [7:0]       n_pairs,
`ifdef STDP_SEQ_ANTI_EN
  input  logic             anti,
`endif
  input  logic             spike_pre,
  input  logic             spike_post,
  output logic [CUR_W-1:0] i_pre,
  output logic [CUR_W-1:0] i_post,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase,
  output logic [7:0]       pair_idx,
  output logic [CNT_W-1:0] cnt_pre,
  output logic [CNT_W-1:0] cnt_post,
  output logic             pass
);

  if (INIT_CYC < 1 || PRE_CYC < 1 || GAP_CYC < 1 || POST_CYC < 1 ||
      REST_CYC < 1 || TEST_CYC < 1) begin : g_cyc_check
    $error("stdp_stim_sequencer: every *_CYC parameter must be >= 1");
  end

  // the sum bounds every individual length, so the timer can hold any load value
  localparam int TMR_W = $clog2(INIT_CYC + PRE_CYC + GAP_CYC + POST_CYC +
                                REST_CYC + TEST_CYC + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         pair_q, pair_d;
  logic [7:0]         np_q, np_d;
  logic [CUR_W-1:0]   amp_pre_q, amp_pre_d;
  logic [CUR_W-1:0]   amp_post_q, amp_post_d;
  logic [CUR_W-1:0]   i_pre_q, i_pre_d;
  logic [CUR_W-1:0]   i_post_q, i_post_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               anti_d;
  logic               start_go;
  logic               en_pre, en_post;
  logic [CNT_W-1:0]   cnt_pre_nxt, cnt_post_nxt;

  function automatic logic [TMR_W-1:0] cyc_load(input state_e s);
    case (s)
      ST_INIT:          cyc_load = TMR_W'(INIT_CYC - 1);
      ST_PRE:           cyc_load = TMR_W'(PRE_CYC - 1);
      ST_GAP1, ST_GAP2: cyc_load = TMR_W'(GAP_CYC - 1);
      ST_POST:          cyc_load = TMR_W'(POST_CYC - 1);
      ST_REST:          cyc_load = TMR_W'(REST_CYC - 1);
      ST_TEST:          cyc_load = TMR_W'(TEST_CYC - 1);
      default:          cyc_load = '0;
    endcase
  endfunction

  // abort in IDLE also suppresses a simultaneous start
  assign start_go = (state_q == ST_IDLE) && start && !abort;

  // an aborting edge freezes the counters
  assign en_pre  = (state_q != ST_IDLE) && !abort;
  assign en_post = (state_q == ST_TEST) && !abort;

`ifdef STDP_SEQ_ANTI_EN
  logic anti_q;
  assign anti_d = start_go ? anti : anti_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anti_q <= 1'b0;
    else        anti_q <= anti_d;
  end
`else
  assign anti_d = 1'b0;
`endif

  // next-state, timer and run bookkeeping
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pair_d     = pair_q;
    np_d       = np_q;
    amp_pre_d  = amp_pre_q;
    amp_post_d = amp_post_q;
    pass_d     = pass_q;
    done_d     = 1'b0;

    if (abort) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        pass_d  = 1'b0;
      end
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        amp_pre_d  = amp_pre;
        amp_post_d = amp_post;
        np_d       = n_pairs;
        pair_d     = 8'd0;
        pass_d     = 1'b0;
        state_d    = ST_INIT;
      end
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end else begin
      case (state_q)
        ST_INIT: state_d = (np_q == 8'd0) ? ST_TEST : ST_PRE;
        ST_PRE:  state_d = ST_GAP1;
        ST_GAP1: state_d = ST_POST;
        ST_POST: state_d = ST_GAP2;
        ST_GAP2: state_d = ST_REST;
        ST_REST: begin
          if (({1'b0, pair_q} + 9'd1) < {1'b0, np_q}) begin
            pair_d  = pair_q + 8'd1;
            state_d = ST_PRE;
          end else begin
            state_d = ST_TEST;
          end
        end
        ST_TEST: begin
          // uses the post-edge counts so a spike in the last TEST cycle counts
          state_d = ST_IDLE;
          done_d  = 1'b1;
          pass_d  = (cnt_pre_nxt != '0) && (cnt_post_nxt != '0);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // every state entry reloads the down-counter
    if (state_d != state_q) begin
      tmr_d = cyc_load(state_d);
    end
  end

  // outputs decoded from the next state so they line up with phase
  always_comb begin
    i_pre_d  = '0;
    i_post_d = '0;
    case (state_d)
      ST_PRE: begin
        if (anti_d) i_post_d = amp_post_d;
        else        i_pre_d  = amp_pre_d;
      end
      ST_POST: begin
        if (anti_d) i_pre_d  = amp_pre_d;
        else        i_post_d = amp_post_d;
      end
      ST_TEST: i_pre_d = amp_pre_d;
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      pair_q     <= 8'd0;
      np_q       <= 8'd0;
      amp_pre_q  <= '0;
      amp_post_q <= '0;
      i_pre_q    <= '0;
      i_post_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pair_q     <= pair_d;
      np_q       <= np_d;
      amp_pre_q  <= amp_pre_d;
      amp_post_q <= amp_post_d;
      i_pre_q    <= i_pre_d;
      i_post_q   <= i_post_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  spike_edge_counter #(.CNT_W(CNT_W)) u_cnt_pre (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_pre),
    .clr       (start_go),
    .spike     (spike_pre),
    .count     (cnt_pre),
    .count_nxt (cnt_pre_nxt)
  );

  spike_edge_counter #(.CNT_W(CNT_W)) u_cnt_post (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_post),
    .clr       (start_go),
    .spike     (spike_post),
    .count     (cnt_post),
    .count_nxt (cnt_post_nxt)
  );

  assign i_pre    = i_pre_q;
  assign i_post   = i_post_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign phase    = state_q;
  assign pair_idx = pair_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_stdp_stim_sequencer.sv
// tb/tb_stdp_stim_sequencer.sv - randomized self-checking bench for stdp_stim_sequencer
// Define STDP_SEQ_ANTI_EN to also exercise the anti-causal ordering input.
module tb_stdp_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, spike_pre, spike_post;
  logic [7:0]  amp_pre, amp_post, n_pairs;
`ifdef STDP_SEQ_ANTI_EN
  logic        anti;
`endif
  logic [7:0]  i_pre, i_post, pair_idx;
  logic        busy, done, pass;
  logic [2:0]  phase;
  logic [15:0] cnt_pre, cnt_post;

  int checks = 0;
  int failures = 0;
  int m_cnt_pre = 0;
  int m_cnt_post = 0;
  int m_pass = 0;

  always #5 clk = ~clk;

  stdp_stim_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .amp_pre    (amp_pre),
    .amp_post   (amp_post),
    .n_pairs    (n_pairs),
`ifdef STDP_SEQ_ANTI_EN
    .anti       (anti),
`endif
    .spike_pre  (spike_pre),
    .spike_post (spike_post),
    .i_pre      (i_pre),
    .i_post     (i_post),
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .pair_idx   (pair_idx),
    .cnt_pre    (cnt_pre),
    .cnt_post   (cnt_post),
    .pass       (pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic anti_pick(input logic want);
`ifdef STDP_SEQ_ANTI_EN
    return want;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_anti(input logic v);
`ifdef STDP_SEQ_ANTI_EN
    anti = v;
`else
    if (v) $display("note: anti request ignored in this build");
`endif
  endtask

  // Which neuron each schedule slot drives: 2=PRE slot, 4=POST slot, 7=TEST.
  function automatic logic [7:0] want_ipre(input int ph, input logic an, input logic [7:0] a);
    if (ph == 7 || (ph == 2 && !an) || (ph == 4 && an)) return a;
    return 8'd0;
  endfunction

  function automatic logic [7:0] want_ipost(input int ph, input logic an, input logic [7:0] a);
    if ((ph == 4 && !an) || (ph == 2 && an)) return a;
    return 8'd0;
  endfunction

  // One run from IDLE; abort_at < 0 means run to completion.
  task automatic run(input int np, input logic [7:0] ap, input logic [7:0] aq,
                     input logic an, input int pre_pct, input int post_pct,
                     input int abort_at);
    int ph[$];
    int pi[$];
    int len;
    logic sp, sq, prev_p, prev_q;
    for (int c = 0; c < 25; c++) begin ph.push_back(1); pi.push_back(0); end
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < 5;  c++) begin ph.push_back(2); pi.push_back(p); end
      for (int c = 0; c < 3;  c++) begin ph.push_back(3); pi.push_back(p); end
      for (int c = 0; c < 5;  c++) begin ph.push_back(4); pi.push_back(p); end
      for (int c = 0; c < 3;  c++) begin ph.push_back(5); pi.push_back(p); end
      for (int c = 0; c < 10; c++) begin ph.push_back(6); pi.push_back(p); end
    end
    for (int c = 0; c < 100; c++) begin ph.push_back(7); pi.push_back(np == 0 ? 0 : np - 1); end
    len = ph.size();

    amp_pre = ap; amp_post = aq; n_pairs = 8'(np); set_anti(an);
    spike_pre = 1'b0; spike_post = 1'b0; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_cnt_pre = 0; m_cnt_post = 0; prev_p = 1'b0; prev_q = 1'b0;

    for (int j = 0; j < len; j++) begin
      sp = ($urandom_range(99) < pre_pct);
      sq = ($urandom_range(99) < post_pct);
      spike_pre = sp; spike_post = sq;
      // scramble latched-on-start inputs and poke start while busy
      amp_pre = 8'($urandom_range(255)); amp_post = 8'($urandom_range(255));
      n_pairs = 8'($urandom_range(255)); set_anti(anti_pick(1'($urandom_range(1))));
      start = ($urandom_range(7) == 0) && (j != abort_at);
      abort = (j == abort_at);
      @(negedge clk);
      check($sformatf("phase[%0d]", j), 32'(phase), 32'(ph[j]));
      check($sformatf("busy[%0d]", j), 32'(busy), 32'd1);
      check($sformatf("done[%0d]", j), 32'(done), 32'd0);
      check($sformatf("i_pre[%0d]", j), 32'(i_pre), 32'(want_ipre(ph[j], an, ap)));
      check($sformatf("i_post[%0d]", j), 32'(i_post), 32'(want_ipost(ph[j], an, aq)));
      check($sformatf("pair_idx[%0d]", j), 32'(pair_idx), 32'(pi[j]));
      check($sformatf("cnt_pre[%0d]", j), 32'(cnt_pre), 32'(m_cnt_pre));
      check($sformatf("cnt_post[%0d]", j), 32'(cnt_post), 32'(m_cnt_post));
      check($sformatf("pass_run[%0d]", j), 32'(pass), 32'd0);
      if (j == abort_at) begin
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; spike_pre = 1'b0; spike_post = 1'b0;
        m_pass = 0;
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_i_pre", 32'(i_pre), 32'd0);
        check("abort_i_post", 32'(i_post), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_cnt_pre", 32'(cnt_pre), 32'(m_cnt_pre));
        check("abort_cnt_post", 32'(cnt_post), 32'(m_cnt_post));
        return;
      end
      if (sp && !prev_p) m_cnt_pre++;
      if (sq && !prev_q && ph[j] == 7) m_cnt_post++;
      prev_p = sp; prev_q = sq;
      @(posedge clk); #1;
    end

    start = 1'b0; spike_pre = 1'b0; spike_post = 1'b0;
    m_pass = (m_cnt_pre != 0 && m_cnt_post != 0) ? 1 : 0;
    check("end_phase", 32'(phase), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_i_pre", 32'(i_pre), 32'd0);
    check("end_i_post", 32'(i_post), 32'd0);
    check("end_cnt_pre", 32'(cnt_pre), 32'(m_cnt_pre));
    check("end_cnt_post", 32'(cnt_post), 32'(m_cnt_post));
    check("end_pass", 32'(pass), 32'(m_pass));
    @(posedge clk); #1;
    check("post_done", 32'(done), 32'd0);
    check("hold_cnt_pre", 32'(cnt_pre), 32'(m_cnt_pre));
    check("hold_cnt_post", 32'(cnt_post), 32'(m_cnt_post));
    check("hold_pass", 32'(pass), 32'(m_pass));
    check("hold_pair_idx", 32'(pair_idx), 32'(pi[len-1]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    amp_pre = 8'd0; amp_post = 8'd0; n_pairs = 8'd0;
    spike_pre = 1'b0; spike_post = 1'b0;
    set_anti(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_i_pre", 32'(i_pre), 32'd0);
    check("rst_i_post", 32'(i_post), 32'd0);
    check("rst_cnt_pre", 32'(cnt_pre), 32'd0);
    check("rst_cnt_post", 32'(cnt_post), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_pair_idx", 32'(pair_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2, 8'h80, 8'h80, 1'b0, 30, 30, -1);
    run(0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), anti_pick(1'b1), 20, 20, -1);
    run(2, 8'h80, 8'h80, 1'b0, 25, 0, 56);
    run(1, 8'h4C, 8'hB3, anti_pick(1'b1), 25, 25, -1);

    // start+abort together, then abort alone, in IDLE: nothing may change
    for (int k = 0; k < 2; k++) begin
      start = (k == 0); abort = 1'b1; amp_pre = 8'h55; n_pairs = 8'd3;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check($sformatf("idle_abort_phase%0d", k), 32'(phase), 32'd0);
      check($sformatf("idle_abort_busy%0d", k), 32'(busy), 32'd0);
      check($sformatf("idle_abort_i_pre%0d", k), 32'(i_pre), 32'd0);
      check($sformatf("idle_abort_cnt_pre%0d", k), 32'(cnt_pre), 32'(m_cnt_pre));
      check($sformatf("idle_abort_pass%0d", k), 32'(pass), 32'(m_pass));
    end

    for (int r = 0; r < 4; r++) begin
      run($urandom_range(0, 3), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
          anti_pick(1'($urandom_range(1))), $urandom_range(5, 40),
          ($urandom_range(2) == 0) ? 0 : 20, -1);
    end

    // asynchronous reset while in PRE
    amp_pre = 8'hA5; amp_post = 8'h3C; n_pairs = 8'd1; set_anti(1'b0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("pre_before_rst_phase", 32'(phase), 32'd2);
    check("pre_before_rst_i_pre", 32'(i_pre), 32'hA5);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_i_pre", 32'(i_pre), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_phase", 32'(phase), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_phase", 32'(phase), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
